// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Purpose  : Shared types for the multicycle core and its memory arbiter.
// Revision : 1.0 - initial release with arbiter state and owner types
// ============================================================================
package risc_pkg;

   // Encoding 0 is the byte size so an all-zero reset drives a legal size.
   typedef enum logic [1:0] {
      DMEM_BYTE = 2'd0,
      DMEM_HALF = 2'd1,
      DMEM_WORD = 2'd2
   } op_enum_dmem_size;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_e;

   function automatic int unsigned age_width(input int unsigned max_wait);
      return $clog2(max_wait + 1);
   endfunction

endpackage : risc_pkg
`default_nettype wire

// File: rtl/arb_age_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_age_counter
// Purpose  : Saturating up-counter with synchronous clear and a saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
module arb_age_counter #(
   parameter int unsigned SAT_VAL = 4,
   parameter int unsigned WIDTH   = $clog2(SAT_VAL + 1)
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             sat
);

   assign sat = (count == WIDTH'(SAT_VAL));

   // Clear wins over increment so a grant always restarts the age from zero.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + 1'b1;
      end
   end

endmodule : arb_age_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and
//            load/store, data first, with an age counter against starvation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import risc_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  res_n,
   // instruction port
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [XLEN-1:0]       i_rdata,
   // data port
   input  logic                  d_req,
   input  logic                  d_wen,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  op_enum_dmem_size      d_size,
   input  logic                  d_zero_ex,
   input  logic [XLEN-1:0]       d_wr_data,
   output logic                  d_ack,
   output logic [XLEN-1:0]       d_rdata,
   // shared memory
   output logic                  mem_req,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output op_enum_dmem_size      mem_size,
   output logic                  mem_zero_ex,
   output logic [XLEN-1:0]       mem_wr_data,
   input  logic [XLEN-1:0]       mem_rd_data,
   output logic                  busy
);

   localparam int unsigned AGE_W = age_width(MAX_WAIT);

   arb_state_e       state;
   arb_state_e       state_next;
   arb_owner_e       owner;
   logic             grant_i;
   logic             grant_d;
   logic             age_inc;
   logic             age_sat;
   logic [AGE_W-1:0] age;

   // The age counts lost arbitrations: each IDLE cycle where fetch was
   // pending but data took the slot.
   assign age_inc = grant_d && i_req;

   arb_age_counter #(
      .SAT_VAL (MAX_WAIT),
      .WIDTH   (AGE_W)
   ) u_age_counter (
      .clk   (clk),
      .res_n (res_n),
      .inc   (age_inc),
      .clr   (grant_i),
      .count (age),
      .sat   (age_sat)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (i_req && (!d_req || age_sat)) begin
               grant_i = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end
            if (grant_i || grant_d) begin
               state_next = ACCESS;
            end
         end
         ACCESS:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command, strobe, ack and read-data registers; the memory only ever sees
   // flop outputs.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         owner       <= OWN_I;
         mem_req     <= 1'b0;
         mem_wen     <= 1'b0;
         mem_addr    <= '0;
         mem_size    <= DMEM_BYTE;
         mem_zero_ex <= 1'b0;
         mem_wr_data <= '0;
         i_ack       <= 1'b0;
         d_ack       <= 1'b0;
         i_rdata     <= '0;
         d_rdata     <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (grant_i) begin
            owner       <= OWN_I;
            mem_req     <= 1'b1;
            mem_wen     <= 1'b0;
            mem_addr    <= i_addr;
            mem_size    <= DMEM_WORD;
            mem_zero_ex <= 1'b1;
         end else if (grant_d) begin
            owner       <= OWN_D;
            mem_req     <= 1'b1;
            mem_wen     <= d_wen;
            mem_addr    <= d_addr;
            mem_size    <= d_size;
            mem_zero_ex <= d_zero_ex;
            mem_wr_data <= d_wr_data;
         end
         if (state == ACCESS) begin
            mem_req <= 1'b0;
            mem_wen <= 1'b0;
            if (owner == OWN_I) begin
               i_ack   <= 1'b1;
               i_rdata <= mem_rd_data;
            end else begin
               d_ack <= 1'b1;
               if (!mem_wen) begin
                  d_rdata <= mem_rd_data;
               end
            end
         end
      end
   end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a small memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   import risc_pkg::*;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned MAX_WAIT   = 4;

   logic                  clk = 1'b0;
   logic                  res_n;
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ack;
   logic [XLEN-1:0]       i_rdata;
   logic                  d_req;
   logic                  d_wen;
   logic [ADDR_WIDTH-1:0] d_addr;
   op_enum_dmem_size      d_size;
   logic                  d_zero_ex;
   logic [XLEN-1:0]       d_wr_data;
   logic                  d_ack;
   logic [XLEN-1:0]       d_rdata;
   logic                  mem_req;
   logic                  mem_wen;
   logic [ADDR_WIDTH-1:0] mem_addr;
   op_enum_dmem_size      mem_size;
   logic                  mem_zero_ex;
   logic [XLEN-1:0]       mem_wr_data;
   logic [XLEN-1:0]       mem_rd_data;
   logic                  busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .XLEN       (XLEN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MAX_WAIT   (MAX_WAIT)
   ) dut (
      .clk         (clk),
      .res_n       (res_n),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_ack       (i_ack),
      .i_rdata     (i_rdata),
      .d_req       (d_req),
      .d_wen       (d_wen),
      .d_addr      (d_addr),
      .d_size      (d_size),
      .d_zero_ex   (d_zero_ex),
      .d_wr_data   (d_wr_data),
      .d_ack       (d_ack),
      .d_rdata     (d_rdata),
      .mem_req     (mem_req),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_size    (mem_size),
      .mem_zero_ex (mem_zero_ex),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data),
      .busy        (busy)
   );

   // Little-endian word memory: extends on read, commits stores on the edge.
   logic [31:0] mem [0:63];
   bit          mem_loaded = 1'b0;

   always_comb begin
      logic [31:0] word;
      logic [7:0]  b;
      logic [15:0] h;
      word = mem[mem_addr[7:2]];
      b    = word[8*mem_addr[1:0] +: 8];
      h    = word[16*mem_addr[1] +: 16];
      mem_rd_data = word;
      if (mem_size == DMEM_BYTE) begin
         mem_rd_data = mem_zero_ex ? {24'd0, b} : {{24{b[7]}}, b};
      end else if (mem_size == DMEM_HALF) begin
         mem_rd_data = mem_zero_ex ? {16'd0, h} : {{16{h[15]}}, h};
      end
   end

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int k = 0; k < 64; k++) mem[k] = 32'd0;
         mem[6'h04] = 32'hDEAD_BEEF;   // 0x10
         mem[6'h0C] = 32'h0000_8000;   // byte 0x31 = 0x80
         mem[6'h10] = 32'h1111_1111;   // 0x40
         mem_loaded = 1'b1;
      end else if (mem_req && mem_wen) begin
         case (mem_size)
            DMEM_BYTE: mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] = mem_wr_data[7:0];
            DMEM_HALF: mem[mem_addr[7:2]][16*mem_addr[1] +: 16] = mem_wr_data[15:0];
            default:   mem[mem_addr[7:2]] = mem_wr_data;
         endcase
      end
   end

   // Request attributes must hold while a request is outstanding.
   logic        d_prev_req = 1'b0, d_prev_ack = 1'b0;
   logic        i_prev_req = 1'b0, i_prev_ack = 1'b0;
   logic [51:0] d_prev_attr = '0;
   logic [15:0] i_prev_attr = '0;
   logic [51:0] d_attr;
   assign d_attr = {d_wen, d_addr, d_size, d_zero_ex, d_wr_data};

   always @(posedge clk) begin
      if (res_n && d_prev_req && d_req && !d_prev_ack)
         assert (d_attr == d_prev_attr) else $error("data port attributes changed mid-request");
      if (res_n && i_prev_req && i_req && !i_prev_ack)
         assert (i_addr == i_prev_attr) else $error("instruction address changed mid-request");
      d_prev_req  <= d_req;
      d_prev_ack  <= d_ack;
      d_prev_attr <= d_attr;
      i_prev_req  <= i_req;
      i_prev_ack  <= i_ack;
      i_prev_attr <= i_addr;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_d(input logic wen, input logic [15:0] addr, input op_enum_dmem_size sz,
                          input logic zx, input logic [31:0] wd);
      d_req     = 1'b1;
      d_wen     = wen;
      d_addr    = addr;
      d_size    = sz;
      d_zero_ex = zx;
      d_wr_data = wd;
   endtask

   initial begin
      res_n = 1'b0; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_size = DMEM_BYTE;
      d_zero_ex = 1'b0; d_wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_strobes", {i_ack, d_ack, mem_req, mem_wen, mem_zero_ex, busy, mem_size}, 64'd0);
      check_eq("rst_rdata", {i_rdata, d_rdata}, 64'd0);
      check_eq("rst_cmd", {mem_addr, mem_wr_data}, 64'd0);
      check_eq("rst_state", 64'(dut.state), 64'(IDLE));
      check_eq("rst_age", 64'(dut.age), 64'd0);
      @(negedge clk) res_n = 1'b1;
      tick();

      // single word load
      drive_d(1'b0, 16'h0010, DMEM_WORD, 1'b1, 32'd0);
      check_eq("ld_c0_busy", 64'(busy), 64'd0);
      tick();
      check_eq("ld_c1_req", {mem_req, busy, mem_wen}, {1'b1, 1'b1, 1'b0});
      check_eq("ld_c1_addr", 64'(mem_addr), 64'h10);
      check_eq("ld_c1_ack", 64'(d_ack), 64'd0);
      tick();
      check_eq("ld_c2_ack", {d_ack, i_ack, mem_req, busy}, {1'b1, 1'b0, 1'b0, 1'b1});
      check_eq("ld_c2_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
      d_req = 1'b0;
      tick();
      check_eq("ld_c3_idle", {d_ack, busy}, 2'b00);
      check_eq("ld_c3_hold", 64'(d_rdata), 64'hDEAD_BEEF);

      // store, then a fetch raised while the store is in flight
      drive_d(1'b1, 16'h0020, DMEM_WORD, 1'b0, 32'h1234_5678);
      tick();
      i_req = 1'b1; i_addr = 16'h0020;
      check_eq("st_c1_cmd", {mem_req, mem_wen, mem_size}, {1'b1, 1'b1, DMEM_WORD});
      check_eq("st_c1_wdata", 64'(mem_wr_data), 64'h1234_5678);
      tick();
      check_eq("st_c2_ack", {d_ack, i_ack}, 2'b10);
      check_eq("st_c2_rdata_kept", 64'(d_rdata), 64'hDEAD_BEEF);
      d_req = 1'b0;
      tick();
      check_eq("st_c3_idle", {busy, mem_req}, 2'b00);
      tick();
      check_eq("fe_c4_cmd", {mem_req, mem_wen, mem_zero_ex, mem_size}, {1'b1, 1'b0, 1'b1, DMEM_WORD});
      check_eq("fe_c4_addr", 64'(mem_addr), 64'h20);
      check_eq("fe_c4_noack", 64'(i_ack), 64'd0);
      tick();
      check_eq("fe_c5_ack", {i_ack, d_ack}, 2'b10);
      check_eq("fe_c5_rdata", 64'(i_rdata), 64'h1234_5678);
      i_req = 1'b0;
      tick();

      // contention: data first, fetch next
      drive_d(1'b0, 16'h0010, DMEM_WORD, 1'b1, 32'd0);
      i_req = 1'b1; i_addr = 16'h0020;
      tick();
      check_eq("ct_c1_addr", 64'(mem_addr), 64'h10);
      tick();
      check_eq("ct_c2_ack", {d_ack, i_ack}, 2'b10);
      d_req = 1'b0;
      tick();
      check_eq("ct_c3_noack", {d_ack, i_ack}, 2'b00);
      tick();
      check_eq("ct_c4_addr", 64'(mem_addr), 64'h20);
      check_eq("ct_c4_age", 64'(dut.age), 64'd0);
      tick();
      check_eq("ct_c5_ack", {d_ack, i_ack}, 2'b01);
      i_req = 1'b0;
      tick();

      // starvation: data held, fetch wins after MAX_WAIT lost arbitrations
      drive_d(1'b0, 16'h0010, DMEM_WORD, 1'b1, 32'd0);
      i_req = 1'b1; i_addr = 16'h0020;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq($sformatf("sv_d%0d_addr", k), 64'(mem_addr), 64'h10);
         tick();
         check_eq($sformatf("sv_d%0d_ack", k), {d_ack, i_ack}, 2'b10);
         tick();
      end
      check_eq("sv_age_sat", 64'(dut.age), 64'(MAX_WAIT));
      tick();
      check_eq("sv_i_addr", 64'(mem_addr), 64'h20);
      check_eq("sv_age_clr", 64'(dut.age), 64'd0);
      tick();
      check_eq("sv_i_ack", {d_ack, i_ack}, 2'b01);
      check_eq("sv_i_rdata", 64'(i_rdata), 64'h1234_5678);
      d_req = 1'b0; i_req = 1'b0;
      tick();

      // byte loads, sign- then zero-extended
      drive_d(1'b0, 16'h0031, DMEM_BYTE, 1'b0, 32'd0);
      tick();
      check_eq("bs_c1_size", {mem_size, mem_zero_ex}, {DMEM_BYTE, 1'b0});
      tick();
      check_eq("bs_c2_rdata", {31'd0, d_ack, d_rdata}, {31'd0, 1'b1, 32'hFFFF_FF80});
      d_req = 1'b0;
      tick();
      drive_d(1'b0, 16'h0031, DMEM_BYTE, 1'b1, 32'd0);
      tick();
      tick();
      check_eq("bz_c2_rdata", {31'd0, d_ack, d_rdata}, {31'd0, 1'b1, 32'h0000_0080});
      check_eq("bz_i_rdata_hold", 64'(i_rdata), 64'h1234_5678);
      d_req = 1'b0;
      tick();

      // asynchronous reset in the middle of a store
      drive_d(1'b1, 16'h0040, DMEM_WORD, 1'b0, 32'hCAFE_F00D);
      tick();
      check_eq("rs_c1_req", {mem_req, mem_wen}, 2'b11);
      #2 res_n = 1'b0;
      #1;
      check_eq("rs_strobes", {i_ack, d_ack, mem_req, mem_wen, mem_zero_ex, busy, mem_size}, 64'd0);
      check_eq("rs_rdata", {i_rdata, d_rdata}, 64'd0);
      check_eq("rs_cmd", {mem_addr, mem_wr_data}, 64'd0);
      d_req = 1'b0;
      tick();
      check_eq("rs_no_ack", {d_ack, mem_req}, 2'b00);
      @(negedge clk) res_n = 1'b1;
      tick();
      check_eq("rs_state", 64'(dut.state), 64'(IDLE));
      check_eq("rs_after", {busy, d_ack, i_ack}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
